// File: rtl/powlib_sfifo.sv
// powlib_sfifo: single-clock elastic FIFO with valid/ready handshaking on both
// sides. Read data is presented show-ahead. Outputs include an occupancy count,
// an almost-full flag and a synchronous flush.
//
// Storage is a W x D array with asynchronous read. D may be any integer >= 2,
// because the pointers wrap by compare-and-reset.
//
// Optional feature: define POWLIB_SFIFO_HWM_EN to add the hwm port. It is a
// high-water mark of cnt, cleared by reset or clr.
//
// Ports:
//   clk     clock, all logic on posedge
//   rst     asynchronous active-low reset
//   clr     synchronous flush, active-high
//   wrdata  write data            wrvld/wrrdy  write handshake
//   rddata  head-of-FIFO data     rdvld/rdrdy  read handshake
//   cnt     occupancy, 0..D
//   aful    cnt >= AFT
//   hwm     max cnt since reset/clr (POWLIB_SFIFO_HWM_EN only)
module powlib_sfifo #(
   parameter int unsigned W    = 16,
   parameter int unsigned D    = 8,
   parameter int unsigned WIDX = $clog2(D),
   parameter int unsigned WCNT = $clog2(D + 1),
   parameter int unsigned AFT  = D - 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic [W-1:0]    wrdata,
   input  logic            wrvld,
   output logic            wrrdy,
   output logic [W-1:0]    rddata,
   output logic            rdvld,
   input  logic            rdrdy,
   output logic [WCNT-1:0] cnt,
`ifdef POWLIB_SFIFO_HWM_EN
   output logic [WCNT-1:0] hwm,
`endif
   output logic            aful
);

   logic [W-1:0]    mem_q [D];
   logic [WIDX-1:0] wrptr_q, wrptr_d;
   logic [WIDX-1:0] rdptr_q, rdptr_d;
   logic [WCNT-1:0] cnt_q, cnt_d;
   logic            wr_fire_c;
   logic            rd_fire_c;

   // Handshake outputs depend only on registered state, clr and rst.
   assign wrrdy  = rst && !clr && (cnt_q != WCNT'(D));
   assign rdvld  = (cnt_q != '0) && !clr;
   assign rddata = mem_q[rdptr_q];
   assign cnt    = cnt_q;
   assign aful   = (cnt_q >= WCNT'(AFT));

   assign wr_fire_c = wrvld && wrrdy;
   assign rd_fire_c = rdvld && rdrdy;

   // Next-state for the pointers and the occupancy count.
   always_comb begin
      wrptr_d = wrptr_q;
      rdptr_d = rdptr_q;
      cnt_d   = cnt_q;
      if (clr) begin
         wrptr_d = '0;
         rdptr_d = '0;
         cnt_d   = '0;
      end else begin
         if (wr_fire_c) begin
            wrptr_d = (wrptr_q == WIDX'(D - 1)) ? '0 : wrptr_q + WIDX'(1);
         end
         if (rd_fire_c) begin
            rdptr_d = (rdptr_q == WIDX'(D - 1)) ? '0 : rdptr_q + WIDX'(1);
         end
         case ({wr_fire_c, rd_fire_c})
            2'b10:   cnt_d = cnt_q + WCNT'(1);
            2'b01:   cnt_d = cnt_q - WCNT'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
         cnt_q   <= '0;
      end else begin
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage array. The array is never reset; flush and reset leave its contents alone.
   always_ff @(posedge clk) begin
      if (wr_fire_c) begin
         mem_q[wrptr_q] <= wrdata;
      end
   end

`ifdef POWLIB_SFIFO_HWM_EN
   logic [WCNT-1:0] hwm_q, hwm_d;

   // Track the peak of the next count, so hwm moves in the same cycle as cnt.
   always_comb begin
      hwm_d = hwm_q;
      if (clr) begin
         hwm_d = '0;
      end else if (cnt_d > hwm_q) begin
         hwm_d = cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hwm_q <= '0;
      end else begin
         hwm_q <= hwm_d;
      end
   end

   assign hwm = hwm_q;
`endif

endmodule
